// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage RV32I core.
// Derives per-stage write enables and flushes from ID hazards, redirects and
// data-memory waits, and runs the halt/drain/resume FSM with a dmem watchdog.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic        PCWrite,
  output logic        IFWrite,
  output logic        IF_flush,
  output logic        ID_flush,
  output logic        EXWrite,
  output logic        MEMWrite,
  output logic        WBWrite,
  output logic        halted,
  output logic        bus_error,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED, ERR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        halted_q, halted_d;
  logic        bus_error_q, bus_error_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic frozen;
  logic freeze_act;
  logic redirect;
  logic timeout;

  assign frozen     = dmem_req & ~dmem_ready;
  assign freeze_act = frozen & ((state_q == RUN) | (state_q == DRAIN));
  assign redirect   = Branch | Jump;
  assign timeout    = freeze_act & (wdog_q == 8'(DMEM_TIMEOUT - 1));

  // Per-stage enables and flushes, combinational from state and inputs
  always_comb begin
    PCWrite  = 1'b0;
    IFWrite  = 1'b0;
    IF_flush = 1'b0;
    ID_flush = 1'b0;
    EXWrite  = 1'b0;
    MEMWrite = 1'b0;
    WBWrite  = 1'b0;
    if (!frozen) begin
      unique case (state_q)
        RUN: begin
          EXWrite  = 1'b1;
          MEMWrite = 1'b1;
          WBWrite  = 1'b1;
          if (Stall) begin
            ID_flush = 1'b1;
          end else if (redirect) begin
            PCWrite  = 1'b1;
            IFWrite  = 1'b1;
            IF_flush = 1'b1;
          end else if (!imem_ready) begin
            IFWrite  = 1'b1;
            IF_flush = 1'b1;
          end else begin
            PCWrite  = 1'b1;
            IFWrite  = 1'b1;
          end
        end
        DRAIN: begin
          ID_flush = 1'b1;
          EXWrite  = 1'b1;
          MEMWrite = 1'b1;
          WBWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state, drain counter, watchdog and statistics
  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    bus_error_d    = bus_error_q;
    wdog_d         = freeze_act ? wdog_q + 8'd1 : '0;
    stall_cycles_d = stall_cycles_q;
    unique case (state_q)
      RUN: begin
        if (timeout) begin
          state_d     = ERR;
          bus_error_d = 1'b1;
        end else if (halt_req && !frozen && !Stall && !redirect) begin
          state_d     = DRAIN;
          drain_cnt_d = 8'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (timeout) begin
          state_d     = ERR;
          bus_error_d = 1'b1;
        end else if (!frozen) begin
          drain_cnt_d = drain_cnt_q - 8'd1;
          if (drain_cnt_q == 8'd1) state_d = HALTED;
        end
      end
      HALTED: begin
        if (resume) state_d = RUN;
      end
      default: ;
    endcase
    halted_d = (state_d == HALTED) | (state_d == ERR);
    if ((state_q == RUN) && !PCWrite && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      drain_cnt_q    <= '0;
      wdog_q         <= '0;
      halted_q       <= 1'b0;
      bus_error_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      wdog_q         <= wdog_d;
      halted_q       <= halted_d;
      bus_error_q    <= bus_error_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign halted       = halted_q;
  assign bus_error    = bus_error_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle expected outputs are queued
// when stimulus is applied and popped/compared on the following falling edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Stall = 1'b0, Branch = 1'b0, Jump = 1'b0, imem_ready = 1'b1;
  logic        dmem_req = 1'b0, dmem_ready = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic        PCWrite, IFWrite, IF_flush, ID_flush, EXWrite, MEMWrite, WBWrite;
  logic        halted, bus_error;
  logic [15:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DRAIN_CYCLES(3), .DMEM_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Branch(Branch), .Jump(Jump),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .resume(resume), .PCWrite(PCWrite), .IFWrite(IFWrite),
    .IF_flush(IF_flush), .ID_flush(ID_flush), .EXWrite(EXWrite),
    .MEMWrite(MEMWrite), .WBWrite(WBWrite), .halted(halted),
    .bus_error(bus_error), .stall_cycles(stall_cycles)
  );

  // Stimulus: {rst_n, Stall, Branch, Jump, imem_ready, dmem_req, dmem_ready, halt_req, resume}
  localparam logic [8:0] S_IDLE   = 9'b1_0001_0000;
  localparam logic [8:0] S_RST    = 9'b0_0001_0000;
  localparam logic [8:0] S_STBR   = 9'b1_1101_0000;
  localparam logic [8:0] S_STALL  = 9'b1_1001_0000;
  localparam logic [8:0] S_BR     = 9'b1_0101_0000;
  localparam logic [8:0] S_JNF    = 9'b1_0010_0000;
  localparam logic [8:0] S_NOF    = 9'b1_0000_0000;
  localparam logic [8:0] S_FRZ    = 9'b1_0001_1000;
  localparam logic [8:0] S_FRZALL = 9'b1_1101_1010;
  localparam logic [8:0] S_STHALT = 9'b1_1001_0010;
  localparam logic [8:0] S_DRDY   = 9'b1_0001_1100;
  localparam logic [8:0] S_HALT   = 9'b1_0001_0010;
  localparam logic [8:0] S_RES    = 9'b1_0001_0001;
  localparam logic [8:0] S_RESH   = 9'b1_0001_0011;

  // Enables: {PCWrite, IFWrite, IF_flush, ID_flush, EXWrite, MEMWrite, WBWrite}
  localparam logic [6:0] EN_RUN   = 7'b1100111;
  localparam logic [6:0] EN_STALL = 7'b0001111;
  localparam logic [6:0] EN_REDIR = 7'b1110111;
  localparam logic [6:0] EN_NOF   = 7'b0110111;
  localparam logic [6:0] EN_DRAIN = 7'b0001111;
  localparam logic [6:0] EN_ZERO  = 7'b0000000;

  typedef struct {
    logic [8:0] stim;
    logic [6:0] en;
    logic       h;
    logic       e;
    logic       inc;
  } row_t;

  typedef struct {
    string       name;
    logic [24:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] exp_stalls = '0;

  function automatic row_t r(logic [8:0] s, logic [6:0] en, logic h, logic er, logic inc);
    row_t x;
    x.stim = s; x.en = en; x.h = h; x.e = er; x.inc = inc;
    return x;
  endfunction

  function automatic logic [24:0] obs();
    return {PCWrite, IFWrite, IF_flush, ID_flush, EXWrite, MEMWrite, WBWrite,
            halted, bus_error, stall_cycles};
  endfunction

  task automatic apply(input logic [8:0] s);
    {rst_n, Stall, Branch, Jump, imem_ready, dmem_req, dmem_ready, halt_req, resume} = s;
  endtask

  task automatic test_reset();
    row_t rows[$];
    rows.push_back(r(S_RST,  EN_RUN, 1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_IDLE, EN_RUN, 1'b0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i].stim);
      if (!rows[i].stim[8]) exp_stalls = '0;
      sb.push_back('{$sformatf("reset[%0d]", i), {rows[i].en, rows[i].h, rows[i].e, exp_stalls}});
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs() !== e.val) begin
        failures++; $display("FAIL %s got=%b expected=%b", e.name, obs(), e.val);
      end
      if (rows[i].inc && exp_stalls != 16'hFFFF) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_redirect();
    row_t rows[$];
    rows.push_back(r(S_STBR, EN_STALL, 1'b0, 1'b0, 1'b1));
    rows.push_back(r(S_IDLE, EN_RUN,   1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_BR,   EN_REDIR, 1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_JNF,  EN_REDIR, 1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_NOF,  EN_NOF,   1'b0, 1'b0, 1'b1));
    rows.push_back(r(S_IDLE, EN_RUN,   1'b0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i].stim);
      sb.push_back('{$sformatf("stall_redirect[%0d]", i), {rows[i].en, rows[i].h, rows[i].e, exp_stalls}});
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs() !== e.val) begin
        failures++; $display("FAIL %s got=%b expected=%b", e.name, obs(), e.val);
      end
      if (rows[i].inc && exp_stalls != 16'hFFFF) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_freeze_priority();
    row_t rows[$];
    rows.push_back(r(S_FRZALL, EN_ZERO,  1'b0, 1'b0, 1'b1));
    rows.push_back(r(S_IDLE,   EN_RUN,   1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_STHALT, EN_STALL, 1'b0, 1'b0, 1'b1));
    rows.push_back(r(S_IDLE,   EN_RUN,   1'b0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i].stim);
      sb.push_back('{$sformatf("freeze_priority[%0d]", i), {rows[i].en, rows[i].h, rows[i].e, exp_stalls}});
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs() !== e.val) begin
        failures++; $display("FAIL %s got=%b expected=%b", e.name, obs(), e.val);
      end
      if (rows[i].inc && exp_stalls != 16'hFFFF) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_drain();
    row_t rows[$];
    rows.push_back(r(S_HALT, EN_RUN,   1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_IDLE, EN_DRAIN, 1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_FRZ,  EN_ZERO,  1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_FRZ,  EN_ZERO,  1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_IDLE, EN_DRAIN, 1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_IDLE, EN_DRAIN, 1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_HALT, EN_ZERO,  1'b1, 1'b0, 1'b0));
    rows.push_back(r(S_RES,  EN_ZERO,  1'b1, 1'b0, 1'b0));
    rows.push_back(r(S_IDLE, EN_RUN,   1'b0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i].stim);
      sb.push_back('{$sformatf("halt_drain[%0d]", i), {rows[i].en, rows[i].h, rows[i].e, exp_stalls}});
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs() !== e.val) begin
        failures++; $display("FAIL %s got=%b expected=%b", e.name, obs(), e.val);
      end
      if (rows[i].inc && exp_stalls != 16'hFFFF) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rehalt_reset();
    row_t rows[$];
    rows.push_back(r(S_HALT, EN_RUN,   1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_HALT, EN_DRAIN, 1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_HALT, EN_DRAIN, 1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_HALT, EN_DRAIN, 1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_RESH, EN_ZERO,  1'b1, 1'b0, 1'b0));
    rows.push_back(r(S_HALT, EN_RUN,   1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_IDLE, EN_DRAIN, 1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_RST,  EN_RUN,   1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_IDLE, EN_RUN,   1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_IDLE, EN_RUN,   1'b0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i].stim);
      if (!rows[i].stim[8]) exp_stalls = '0;
      sb.push_back('{$sformatf("rehalt_reset[%0d]", i), {rows[i].en, rows[i].h, rows[i].e, exp_stalls}});
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs() !== e.val) begin
        failures++; $display("FAIL %s got=%b expected=%b", e.name, obs(), e.val);
      end
      if (rows[i].inc && exp_stalls != 16'hFFFF) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog();
    row_t rows[$];
    for (int k = 0; k < 254; k++) rows.push_back(r(S_FRZ, EN_ZERO, 1'b0, 1'b0, 1'b1));
    rows.push_back(r(S_DRDY, EN_RUN, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 255; k++) rows.push_back(r(S_FRZ, EN_ZERO, 1'b0, 1'b0, 1'b1));
    rows.push_back(r(S_FRZ,  EN_ZERO, 1'b1, 1'b1, 1'b0));
    rows.push_back(r(S_RES,  EN_ZERO, 1'b1, 1'b1, 1'b0));
    rows.push_back(r(S_IDLE, EN_ZERO, 1'b1, 1'b1, 1'b0));
    rows.push_back(r(S_RST,  EN_RUN,  1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_IDLE, EN_RUN,  1'b0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i].stim);
      if (!rows[i].stim[8]) exp_stalls = '0;
      sb.push_back('{$sformatf("watchdog[%0d]", i), {rows[i].en, rows[i].h, rows[i].e, exp_stalls}});
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs() !== e.val) begin
        failures++; $display("FAIL %s got=%b expected=%b", e.name, obs(), e.val);
      end
      if (rows[i].inc && exp_stalls != 16'hFFFF) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate();
    row_t rows[$];
    apply(S_STALL);
    repeat (70000) @(posedge clk);
    #1;
    exp_stalls = 16'hFFFF;
    rows.push_back(r(S_STALL, EN_STALL, 1'b0, 1'b0, 1'b1));
    rows.push_back(r(S_IDLE,  EN_RUN,   1'b0, 1'b0, 1'b0));
    rows.push_back(r(S_IDLE,  EN_RUN,   1'b0, 1'b0, 1'b0));
    foreach (rows[i]) begin
      apply(rows[i].stim);
      sb.push_back('{$sformatf("saturate[%0d]", i), {rows[i].en, rows[i].h, rows[i].e, exp_stalls}});
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if (obs() !== e.val) begin
        failures++; $display("FAIL %s got=%b expected=%b", e.name, obs(), e.val);
      end
      if (rows[i].inc && exp_stalls != 16'hFFFF) exp_stalls++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_stall_redirect();
    test_freeze_priority();
    test_halt_drain();
    test_rehalt_reset();
    test_watchdog();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
